pulse_meas: RTL and testbench

PULSE_MEAS -- requirements
Module: pulse_meas

---
 rtl/pulse_meas.sv | 180 ++++++++++++++++++
 tb/tb_pulse_meas.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_meas.sv
// ---------------------------------------------------------------------------
// pulse_meas -- measures the width of high pulses on PIN, in CLK cycles.
//
// A pulse is counted from its first sampled-high cycle. When it ends it is
// classified as one of three outcomes:
//   accepted : MIN..MAX cycles, reported on WIDTH with a one-cycle VALID,
//   runt     : fewer than MIN cycles, dropped with a one-cycle RUNT,
//   overflow : more than MAX cycles, WIDTH is set to MAX with a one-cycle OVF.
//
// Parameters
//   MAX  longest accepted width (8 bit, default 8'hFF)
//   MIN  shortest accepted width (8 bit, default 1; 0 behaves as 1)
//
// Ports
//   CLK     in   rising-edge clock
//   R       in   asynchronous active-low reset
//   EN      in   measurement enable; dropping it aborts a pulse silently
//   PIN     in   pulse input (high-active)
//   WIDTH   out  last accepted or overflowed width (8 bit)
//   VALID   out  one-cycle strobe, WIDTH holds a new accepted width
//   RUNT    out  one-cycle strobe, a too-short pulse was discarded
//   OVF     out  one-cycle strobe, a pulse exceeded MAX
//   BUSY    out  high while a pulse is being measured or waited out
//   PCOUNT  out  number of VALID strobes, wraps modulo 256
//
// Build option
//   PULSE_MEAS_SYNC_EN  when defined, PIN passes a 2-flop synchronizer
//                       before the sampling flop (PIN may then be
//                       asynchronous); strobes arrive 2 cycles later and
//                       widths are unchanged. When undefined, PIN must be
//                       synchronous to CLK and is registered once.
// ---------------------------------------------------------------------------
module pulse_meas #(
    parameter logic [7:0] MAX = 8'hFF,
    parameter logic [7:0] MIN = 8'd1
) (
    input  logic       CLK,
    input  logic       R,
    input  logic       EN,
    input  logic       PIN,
    output logic [7:0] WIDTH,
    output logic       VALID,
    output logic       RUNT,
    output logic       OVF,
    output logic       BUSY,
    output logic [7:0] PCOUNT
);

    // A zero minimum would be meaningless: every measured pulse has at
    // least one sampled-high cycle.
    localparam logic [7:0] MIN_EFF = (MIN == 8'd0) ? 8'd1 : MIN;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HIGH     = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Input sampling: every decision below looks only at s_q.
    // -----------------------------------------------------------------------
    logic s_q;

`ifdef PULSE_MEAS_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            sync_q <= 2'b00;
            s_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], PIN};
            s_q    <= sync_q[1];
        end
    end
`else
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            s_q <= 1'b0;
        end else begin
            s_q <= PIN;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Measurement FSM
    // -----------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] width_q, width_d;
    logic [7:0] pcount_q, pcount_d;
    logic       valid_q, valid_d;
    logic       runt_q, runt_d;
    logic       ovf_q, ovf_d;

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'h00;
            width_q  <= 8'h00;
            pcount_q <= 8'h00;
            valid_q  <= 1'b0;
            runt_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            width_q  <= width_d;
            pcount_q <= pcount_d;
            valid_q  <= valid_d;
            runt_q   <= runt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        width_d  = width_q;
        pcount_d = pcount_q;
        valid_d  = 1'b0;
        runt_d   = 1'b0;
        ovf_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The sample that triggers the start is the pulse's first
                // high cycle, hence the count starts at 1.
                if (EN && s_q) begin
                    cnt_d   = 8'd1;
                    state_d = ST_HIGH;
                end
            end

            ST_HIGH: begin
                if (!EN) begin
                    // Aborted measurement: no strobe, results untouched.
                    state_d = ST_IDLE;
                end else if (s_q) begin
                    if (cnt_q < MAX) begin
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        // This is high sample MAX+1: the pulse is too long.
                        width_d = MAX;
                        ovf_d   = 1'b1;
                        state_d = ST_WAIT_LOW;
                    end
                end else if (cnt_q >= MIN_EFF) begin
                    width_d  = cnt_q;
                    valid_d  = 1'b1;
                    pcount_d = pcount_q + 8'd1;
                    state_d  = ST_IDLE;
                end else begin
                    runt_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT_LOW: begin
                // Remainder of an overflowed pulse is ignored silently.
                if (!EN || !s_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign WIDTH  = width_q;
    assign PCOUNT = pcount_q;
    assign VALID  = valid_q;
    assign RUNT   = runt_q;
    assign OVF    = ovf_q;
    assign BUSY   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pulse_meas.sv
// ---------------------------------------------------------------------------
// tb_pulse_meas -- self-checking bench for pulse_meas (MAX=10, MIN=3).
//
// Pulses are described by their high and low lengths. For each pulse the
// expected outcome (accepted / runt / overflow), the cycle its strobe appears
// and the cycles BUSY is high are derived directly from the pulse length;
// a per-cycle monitor compares the DUT against those predictions. Enable
// abort and mid-pulse reset are exercised as directed sequences.
// ---------------------------------------------------------------------------
module tb_pulse_meas;

    localparam logic [7:0] MAX = 8'd10;
    localparam logic [7:0] MIN = 8'd3;
`ifdef PULSE_MEAS_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int N = 16384;

    logic       CLK = 1'b0;
    logic       R   = 1'b0;
    logic       EN  = 1'b0;
    logic       PIN = 1'b0;
    logic [7:0] WIDTH;
    logic       VALID;
    logic       RUNT;
    logic       OVF;
    logic       BUSY;
    logic [7:0] PCOUNT;

    pulse_meas #(
        .MAX(MAX),
        .MIN(MIN)
    ) dut (
        .CLK   (CLK),
        .R     (R),
        .EN    (EN),
        .PIN   (PIN),
        .WIDTH (WIDTH),
        .VALID (VALID),
        .RUNT  (RUNT),
        .OVF   (OVF),
        .BUSY  (BUSY),
        .PCOUNT(PCOUNT)
    );

    always #5 CLK = ~CLK;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: observed %0d, expected %0d",
                     tag, cyc, obs, exp_v);
        end
    endtask

    // Prediction tables indexed by edge number.
    // evt_kind: 0 none, 1 accepted, 2 runt, 3 overflow.
    byte unsigned evt_kind [N];
    int           evt_w    [N];
    bit           exp_busy [N];

    bit chk_on       = 1'b0;
    int model_width  = 0;
    int model_pcount = 0;
    int strobe_seen  = 0;
    int k;
    int exp_bits;

    // A pulse whose first high sample is captured at edge k0 and which
    // lasts h cycles: BUSY covers edges k0+1..k0+h, and the outcome is
    // reported after edge k0+min(h,MAX)+1 (shifted by the sync latency).
    function automatic void schedule(input int k0, input int h);
        int se;
        int m;
        m  = (h < int'(MAX)) ? h : int'(MAX);
        se = k0 + m + 1 + LAT;
        for (int e = k0 + 1 + LAT; e <= k0 + h + LAT; e++) begin
            if (e < N) exp_busy[e] = 1'b1;
        end
        if (se < N) begin
            if (h > int'(MAX))      evt_kind[se] = 8'd3;
            else if (h < int'(MIN)) evt_kind[se] = 8'd2;
            else                    evt_kind[se] = 8'd1;
            evt_w[se] = h;
        end
    endfunction

    // Per-cycle monitor, away from the active edge.
    always @(negedge CLK) begin
        if (VALID || RUNT || OVF) strobe_seen++;
        if (chk_on && cyc < N) begin
            k = int'(evt_kind[cyc]);
            if (k == 1) begin
                model_width  = evt_w[cyc];
                model_pcount = (model_pcount + 1) % 256;
            end else if (k == 3) begin
                model_width = int'(MAX);
            end
            exp_bits = (k == 1) ? 4 : (k == 2) ? 2 : (k == 3) ? 1 : 0;
            check("strobes{V,R,O}", int'({VALID, RUNT, OVF}), exp_bits);
            check("width", int'(WIDTH), model_width);
            check("pcount", int'(PCOUNT), model_pcount);
            check("busy", int'(BUSY), int'(exp_busy[cyc]));
        end
    end

    // Called at a falling edge with EN=1.
    task automatic send_pulse(input int h, input int l);
        string outcome;
        if (h > int'(MAX))      outcome = "overflow";
        else if (h < int'(MIN)) outcome = "runt";
        else                    outcome = "accepted";
        $display("pulse: high=%0d low=%0d first_edge=%0d expect=%s",
                 h, l, cyc + 1, outcome);
        schedule(cyc + 1, h);
        PIN = 1'b1;
        repeat (h) @(negedge CLK);
        PIN = 1'b0;
        repeat (l) @(negedge CLK);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_width"}, int'(WIDTH), 0);
        check({tag, "_pcount"}, int'(PCOUNT), 0);
        check({tag, "_strobes"}, int'({VALID, RUNT, OVF}), 0);
        check({tag, "_busy"}, int'(BUSY), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        R  = 1'b1;
        EN = 1'b1;
        @(negedge CLK);
        chk_on = 1'b1;

        // ---------------- directed pulses ----------------
        send_pulse(5, 3);               // basic accept
        send_pulse(2, 2);               // runt (below MIN)
        send_pulse(3, 1);               // exactly MIN
        send_pulse(1, 1);               // shortest runt
        send_pulse(10, 2);              // exactly MAX
        send_pulse(11, 2);              // MAX+1 overflows
        send_pulse(20, 3);              // long overflow
        send_pulse(4, 1);               // back-to-back with one low cycle
        send_pulse(6, 2);

        // ---------------- random pulses (PCOUNT wraps) ----------------
        for (int i = 0; i < 600; i++) begin
            send_pulse(int'($urandom_range(1, 14)), int'($urandom_range(1, 4)));
        end
        repeat (8) @(negedge CLK);

        // ---------------- EN dropped mid-pulse ----------------
        chk_on = 1'b0;
        s0  = strobe_seen;
        PIN = 1'b1;
        repeat (3 + LAT) @(negedge CLK);
        check("en_busy_during", int'(BUSY), 1);
        EN = 1'b0;
        repeat (4) @(negedge CLK);
        check("en_busy_after", int'(BUSY), 0);
        repeat (2) @(negedge CLK);
        PIN = 1'b0;
        repeat (4 + LAT) @(negedge CLK);
        check("en_no_strobe", strobe_seen - s0, 0);
        check("en_width_kept", int'(WIDTH), model_width);
        check("en_pcount_kept", int'(PCOUNT), model_pcount);
        EN = 1'b1;
        @(negedge CLK);
        chk_on = 1'b1;
        repeat (2) @(negedge CLK);
        send_pulse(7, 2);
        repeat (4) @(negedge CLK);

        // ---------------- reset on the 3rd cycle of an 8-cycle pulse -----
        chk_on = 1'b0;
        PIN = 1'b1;
        repeat (2 + LAT) @(negedge CLK);
        check("rst_busy_before", int'(BUSY), 1);
        R = 1'b0;
        #1;
        check_all_zero("midpulse_reset");
        @(negedge CLK);
        check_all_zero("held_reset");
        // PIN is still high at release: measured from the first sample.
        R = 1'b1;
        model_width  = 0;
        model_pcount = 0;
        $display("pulse: high=5 (already high at reset release) first_edge=%0d expect=accepted",
                 cyc + 1);
        schedule(cyc + 1, 5);
        @(negedge CLK);
        chk_on = 1'b1;
        repeat (4) @(negedge CLK);
        PIN = 1'b0;
        repeat (3) @(negedge CLK);
        send_pulse(9, 2);
        send_pulse(12, 2);
        repeat (8) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
